// File: rtl/led_matrix_pkg.sv
// Shared types and constants for the 4x4 LED matrix scanner.
package led_matrix_pkg;

    localparam int ROWS = 4;
    localparam int COLS = 4;

    typedef logic [1:0] row_idx_t;
    typedef logic [1:0] col_idx_t;

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        ON
    } state_t;

    function automatic logic [ROWS-1:0] row_onehot(input row_idx_t r);
        logic [ROWS-1:0] v;
        v    = '0;
        v[r] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// PWM tick prescaler: one tick every PRESCALE cycles while run is high, held at 0 otherwise.
module led_tick_gen #(
    parameter int PRESCALE = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic tick
);

    localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (rst || !run) begin
            cnt_reg <= '0;
        end else if (cnt_reg == CNT_LAST) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

    assign tick = run && (cnt_reg == CNT_LAST);

endmodule

// File: rtl/led_matrix_scan.sv
// 4x4 LED matrix row scanner with PWM brightness and inter-row blanking.
// Define LED_MATRIX_DOUBLE_BUF_EN for a front/back framebuffer pair swapped at frame end.
module led_matrix_scan
    import led_matrix_pkg::*;
#(
    parameter int PRESCALE    = 2,
    parameter int BRIGHT_W    = 4,
    parameter int BLANK_TICKS = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                wr_en,
    input  logic [1:0]          wr_row,
    input  logic [1:0]          wr_col,
    input  logic [BRIGHT_W-1:0] wr_data,
    input  logic                swap_req,
    output logic [3:0]          aled,
    output logic [3:0]          kled_oe,
    output logic                frame_tick,
    output logic                swap_pending
);

`ifdef LED_MATRIX_DOUBLE_BUF_EN
    localparam int NBANK = 2;
`else
    localparam int NBANK = 1;
`endif
    localparam int NPIX    = NBANK * ROWS * COLS;
    localparam int ADDR_W  = $clog2(NPIX);
    localparam int BLANK_W = (BLANK_TICKS > 1) ? $clog2(BLANK_TICKS) : 1;
    localparam logic [BLANK_W-1:0]  BLANK_LAST = BLANK_W'((BLANK_TICKS > 0) ? BLANK_TICKS - 1 : 0);
    localparam logic [BRIGHT_W-1:0] PWM_LAST   = BRIGHT_W'((1 << BRIGHT_W) - 2);
    localparam state_t ROW_START = (BLANK_TICKS == 0) ? ON : BLANK;

    state_t             state_reg, state_next;
    row_idx_t           row_reg, row_next;
    logic [BRIGHT_W-1:0] pwm_reg, pwm_next;
    logic [BLANK_W-1:0]  blank_reg, blank_next;
    logic               frame_end;
    logic               tick;

    logic [ROWS-1:0]    aled_reg;
    logic [COLS-1:0]    kled_reg;
    logic [COLS-1:0]    lit;

    logic [ADDR_W-1:0]  wr_idx;
    logic [ADDR_W-1:0]  rd_base;
    logic [NPIX-1:0][BRIGHT_W-1:0] fb_q;

    led_tick_gen #(
        .PRESCALE(PRESCALE)
    ) u_tick (
        .clk (clk),
        .rst (rst),
        .run (state_reg != IDLE),
        .tick(tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            row_reg   <= '0;
            pwm_reg   <= '0;
            blank_reg <= '0;
        end else begin
            state_reg <= state_next;
            row_reg   <= row_next;
            pwm_reg   <= pwm_next;
            blank_reg <= blank_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        row_next   = row_reg;
        pwm_next   = pwm_reg;
        blank_next = blank_reg;
        frame_end  = 1'b0;
        if (!en) begin
            state_next = IDLE;
            row_next   = '0;
            pwm_next   = '0;
            blank_next = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    state_next = ROW_START;
                    pwm_next   = '0;
                    blank_next = '0;
                end
                BLANK: begin
                    if (tick) begin
                        if (blank_reg == BLANK_LAST) begin
                            state_next = ON;
                            pwm_next   = '0;
                            blank_next = '0;
                        end else begin
                            blank_next = blank_reg + BLANK_W'(1);
                        end
                    end
                end
                ON: begin
                    if (tick) begin
                        if (pwm_reg == PWM_LAST) begin
                            // Last PWM slot of this row: advance and flag the frame end after row 3
                            row_next   = row_reg + row_idx_t'(1);
                            state_next = ROW_START;
                            pwm_next   = '0;
                            frame_end  = (row_reg == row_idx_t'(ROWS - 1));
                        end else begin
                            pwm_next = pwm_reg + BRIGHT_W'(1);
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Bank select and swap handshake
`ifdef LED_MATRIX_DOUBLE_BUF_EN
    logic bank_sel_reg;
    logic swap_pending_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            bank_sel_reg     <= 1'b0;
            swap_pending_reg <= 1'b0;
        end else if (frame_end && (swap_pending_reg || swap_req)) begin
            bank_sel_reg     <= ~bank_sel_reg;
            swap_pending_reg <= 1'b0;
        end else if (swap_req) begin
            swap_pending_reg <= 1'b1;
        end
    end

    assign wr_idx       = {~bank_sel_reg, wr_row, wr_col};
    assign rd_base      = {bank_sel_reg, row_reg, 2'b00};
    assign swap_pending = swap_pending_reg;
`else
    logic unused_swap_req;

    assign unused_swap_req = swap_req;
    assign wr_idx          = {wr_row, wr_col};
    assign rd_base         = {row_reg, 2'b00};
    assign swap_pending    = 1'b0;
`endif

    // Framebuffer kept in flops: it must clear on reset and be readable by all columns at once
    for (genvar gi = 0; gi < NPIX; gi++) begin : g_pix
        logic [BRIGHT_W-1:0] pix_reg;

        always_ff @(posedge clk) begin
            if (rst) begin
                pix_reg <= '0;
            end else if (wr_en && (wr_idx == ADDR_W'(gi))) begin
                pix_reg <= wr_data;
            end
        end

        assign fb_q[gi] = pix_reg;
    end

    for (genvar gi = 0; gi < COLS; gi++) begin : g_col
        assign lit[gi] = (pwm_reg < fb_q[rd_base + ADDR_W'(gi)]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            aled_reg <= '0;
            kled_reg <= '0;
        end else if (en && (state_reg == ON)) begin
            aled_reg <= row_onehot(row_reg);
            kled_reg <= lit;
        end else begin
            aled_reg <= '0;
            kled_reg <= '0;
        end
    end

    assign aled       = aled_reg;
    assign kled_oe    = kled_reg;
    assign frame_tick = frame_end;

endmodule

// File: tb/tb_led_matrix_scan.sv
// Scoreboard bench for led_matrix_scan: each row ON window is captured and compared to a queued expectation.
`timescale 1ns/1ps
module tb_led_matrix_scan;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       wr_en = 1'b0;
    logic [1:0] wr_row = '0;
    logic [1:0] wr_col = '0;
    logic [3:0] wr_data = '0;
    logic       swap_req = 1'b0;
    logic [3:0] aled;
    logic [3:0] kled_oe;
    logic       frame_tick;
    logic       swap_pending;

    always #5 clk = ~clk;

    led_matrix_scan #(
        .PRESCALE(2),
        .BRIGHT_W(4),
        .BLANK_TICKS(2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .wr_en       (wr_en),
        .wr_row      (wr_row),
        .wr_col      (wr_col),
        .wr_data     (wr_data),
        .swap_req    (swap_req),
        .aled        (aled),
        .kled_oe     (kled_oe),
        .frame_tick  (frame_tick),
        .swap_pending(swap_pending)
    );

    typedef struct packed {
        logic [3:0]      aled;
        logic [7:0]      len;
        logic [3:0][7:0] on;
        logic            ft;
        logic            chk_blank;
    } win_t;

    win_t exp_q[$];
    win_t mon_e;
    int   checks = 0;
    int   errors = 0;

    // Monitor state: current window and the all-off run before it
    int              cyc = 0;
    int              win_done = 0;
    int              zero_run = 0;
    int              last_ft = 0;
    bit              ft_valid = 1'b0;
    bit              in_win = 1'b0;
    bit              blank_kled = 1'b0;
    logic [3:0]      w_aled = '0;
    int              w_len = 0;
    int              w_blank = 0;
    logic [3:0][7:0] w_on = '0;
    logic            w_ft = 1'b0;
    logic            w_blank_kled = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (!$isunknown(aled) && aled != 4'b0) begin
            if (!in_win) begin
                in_win       = 1'b1;
                w_aled       = aled;
                w_len        = 0;
                w_on         = '0;
                w_ft         = 1'b0;
                w_blank      = zero_run;
                w_blank_kled = blank_kled;
            end
            w_len++;
            for (int c = 0; c < 4; c++) begin
                if (kled_oe[c] === 1'b1) w_on[c] = w_on[c] + 8'd1;
            end
            if (frame_tick === 1'b1) w_ft = 1'b1;
        end else begin
            if (in_win) begin
                in_win = 1'b0;
                win_done++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL window_unexpected: got aled=%b len=%0d, expected no window", w_aled, w_len);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (w_aled !== mon_e.aled || w_len != int'(mon_e.len) || w_on !== mon_e.on ||
                        w_ft !== mon_e.ft ||
                        (mon_e.chk_blank && (w_blank != 4 || w_blank_kled))) begin
                        errors++;
                        $display("FAIL window: got aled=%b len=%0d on=%0d/%0d/%0d/%0d ft=%0b blank=%0d blank_kled=%0b, expected aled=%b len=%0d on=%0d/%0d/%0d/%0d ft=%0b blank=%s",
                                 w_aled, w_len, w_on[0], w_on[1], w_on[2], w_on[3], w_ft, w_blank, w_blank_kled,
                                 mon_e.aled, mon_e.len, mon_e.on[0], mon_e.on[1], mon_e.on[2], mon_e.on[3],
                                 mon_e.ft, mon_e.chk_blank ? "4" : "any");
                    end else begin
                        $display("window aled=%b len=%0d on=%0d/%0d/%0d/%0d ft=%0b ok",
                                 w_aled, w_len, w_on[0], w_on[1], w_on[2], w_on[3], w_ft);
                    end
                end
                zero_run   = 0;
                blank_kled = 1'b0;
            end
            zero_run++;
            if (kled_oe !== 4'b0) blank_kled = 1'b1;
        end

        if (rst || !en) begin
            ft_valid = 1'b0;
        end else if (frame_tick === 1'b1) begin
            if (ft_valid) begin
                checks++;
                if (cyc - last_ft != 136) begin
                    errors++;
                    $display("FAIL frame_period: got %0d cycles, expected 136", cyc - last_ft);
                end else begin
                    $display("frame_period %0d cycles ok", cyc - last_ft);
                end
            end
            last_ft  = cyc;
            ft_valid = 1'b1;
        end
    end

    task automatic push_win(input int row, input int len, input int o0, input int o1,
                            input int o2, input int o3, input bit chk);
        win_t e;
        e.aled      = 4'b0001 << row;
        e.len       = 8'(len);
        e.on[0]     = 8'(o0);
        e.on[1]     = 8'(o1);
        e.on[2]     = 8'(o2);
        e.on[3]     = 8'(o3);
        e.ft        = (row == 3) && (len >= 29);
        e.chk_blank = chk;
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input int got, input int expv);
        checks++;
        if (got != expv) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, expv);
        end else begin
            $display("check %s = %0d ok", name, got);
        end
    endtask

    task automatic wait_windows(input int n);
        int target;
        int budget;
        target = win_done + n;
        budget = 0;
        while (win_done < target && budget < 2000) begin
            @(posedge clk);
            budget++;
        end
        if (win_done < target) begin
            checks++;
            errors++;
            $display("FAIL wait_windows: got %0d windows, expected %0d", win_done, target);
        end
    endtask

    task automatic wait_win(input logic [3:0] a, input int len);
        int budget;
        budget = 0;
        while (!(in_win && w_aled == a && w_len == len) && budget < 1000) begin
            @(posedge clk);
            budget++;
        end
        if (budget >= 1000) begin
            checks++;
            errors++;
            $display("FAIL wait_win: got no window aled=%b reaching len %0d, expected one", a, len);
        end
    endtask

    task automatic write_px(input int r, input int c, input int d);
        wr_en   = 1'b1;
        wr_row  = 2'(r);
        wr_col  = 2'(c);
        wr_data = 4'(d);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // Reset in the 4th cycle of a lit window, then confirm a cleared framebuffer after restart
    task automatic reset_mid(input logic [3:0] a);
        wait_win(a, 3);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_aled", int'(aled), 0);
        check("rst_kled", int'(kled_oe), 0);
        check("rst_frame_tick", int'(frame_tick), 0);
        check("rst_swap_pending", int'(swap_pending), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int r = 0; r < 4; r++) push_win(r, 30, 0, 0, 0, 0, r != 0);
        wait_windows(4);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        check("reset_aled", int'(aled), 0);
        check("reset_kled", int'(kled_oe), 0);
        check("reset_frame_tick", int'(frame_tick), 0);
        check("reset_swap_pending", int'(swap_pending), 0);
        rst = 1'b0;

        // Blank image: eight dark rows, two frames
        for (int i = 0; i < 8; i++) push_win(i % 4, 30, 0, 0, 0, 0, i != 0);
        en = 1'b1;
        wait_windows(8);

`ifdef LED_MATRIX_DOUBLE_BUF_EN
        for (int r = 0; r < 4; r++) push_win(r, 30, 0, 0, 0, 0, 1'b1);
        @(negedge clk);
        write_px(0, 1, 15);
        wait_win(4'b0010, 5);
        @(negedge clk);
        swap_req = 1'b1;
        @(negedge clk);
        swap_req = 1'b0;
        check("swap_pending_set", int'(swap_pending), 1);
        push_win(0, 30, 0, 30, 0, 0, 1'b1);
        for (int r = 1; r < 4; r++) push_win(r, 30, 0, 0, 0, 0, 1'b1);
        wait_win(4'b1000, 5);
        @(negedge clk);
        check("swap_pending_hold", int'(swap_pending), 1);
        wait_windows(1);
        @(negedge clk);
        check("swap_pending_clear", int'(swap_pending), 0);
        write_px(2, 2, 15);
        wait_win(4'b1000, 28);
        @(negedge clk);
        check("frame_tick_seen", int'(frame_tick), 1);
        swap_req = 1'b1;
        @(negedge clk);
        swap_req = 1'b0;
        check("swap_same_cycle_pending", int'(swap_pending), 0);
        for (int r = 0; r < 4; r++) push_win(r, 30, 0, 0, (r == 2) ? 30 : 0, 0, 1'b1);
        wait_windows(4);
        push_win(0, 30, 0, 0, 0, 0, 1'b1);
        push_win(1, 30, 0, 0, 0, 0, 1'b1);
        push_win(2, 4, 0, 0, 4, 0, 1'b1);
        reset_mid(4'b0100);
`else
        push_win(0, 30, 0, 0, 0, 0, 1'b1);
        push_win(1, 30, 0, 0, 30, 10, 1'b1);
        push_win(2, 11, 0, 0, 0, 0, 1'b1);
        @(negedge clk);
        write_px(1, 2, 15);
        write_px(1, 3, 5);
        wait_win(4'b0100, 10);
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        check("endrop_aled", int'(aled), 0);
        check("endrop_kled", int'(kled_oe), 0);
        @(negedge clk);
        write_px(0, 0, 8);
        push_win(0, 30, 7, 0, 0, 0, 1'b0);
        push_win(1, 30, 0, 0, 30, 10, 1'b1);
        en = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (aled == 4'b0 && n < 20);
        check("reenable_zero_cycles", n - 1, 5);
        check("reenable_aled", int'(aled), 1);
        wait_win(4'b0001, 5);
        @(negedge clk);
        write_px(0, 0, 0);
        wait_windows(2);
        push_win(2, 30, 0, 0, 0, 0, 1'b1);
        push_win(3, 30, 0, 0, 0, 0, 1'b1);
        push_win(0, 30, 0, 0, 0, 0, 1'b1);
        push_win(1, 4, 0, 0, 4, 4, 1'b1);
        reset_mid(4'b0010);
`endif

        repeat (5) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
